operand_issue: RTL

//   Drives the register file from the core side.

---
 rtl/operand_issue.sv | 111 +++++++++++
 1 files changed

// File: rtl/operand_issue.sv
// Operand issue stage: reads the register file for decoded instructions, bypasses
// same-cycle writeback data, stalls on pending destinations and registers operands for execute.
module operand_issue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [ADDR_W-1:0] dec_rs1,
  input  logic [ADDR_W-1:0] dec_rs2,
  input  logic [ADDR_W-1:0] dec_rd,
  input  logic              dec_wen,
  input  logic [OP_W-1:0]   dec_op,
  output logic [ADDR_W-1:0] rf_rega,
  output logic [ADDR_W-1:0] rf_regb,
  input  logic [DATA_W-1:0] rf_read1,
  input  logic [DATA_W-1:0] rf_read2,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_wreg,
  output logic [DATA_W-1:0] rf_writedata,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_wen,
  output logic [OP_W-1:0]   ex_op
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [NREG-1:0]   r_pending;
  logic [NREG-1:0]   w_clr;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_busy;
  logic              w_hazard;
  logic              w_accept;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;

  logic              r_ex_valid;
  logic [DATA_W-1:0] r_ex_a;
  logic [DATA_W-1:0] r_ex_b;
  logic [ADDR_W-1:0] r_ex_rd;
  logic              r_ex_wen;
  logic [OP_W-1:0]   r_ex_op;

  assign rf_rega      = dec_rs1;
  assign rf_regb      = dec_rs2;
  assign rf_write_en  = wb_valid & ~rst;
  assign rf_wreg      = wb_rd;
  assign rf_writedata = wb_data;

  // The regfile write lands at the edge, after the combinational read, so forward it here.
  assign w_opa = (wb_valid && (wb_rd == dec_rs1)) ? wb_data : rf_read1;
  assign w_opb = (wb_valid && (wb_rd == dec_rs2)) ? wb_data : rf_read2;

  assign w_accept = dec_valid & dec_ready;

  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      w_clr[i] = wb_valid && (wb_rd == ADDR_W'(i));
      w_set[i] = w_accept && dec_wen && (dec_rd == ADDR_W'(i));
    end
  end

  assign w_busy    = r_pending & ~w_clr;
  assign w_hazard  = w_busy[dec_rs1] | w_busy[dec_rs2] | (dec_wen & w_busy[dec_rd]);
  assign dec_ready = ~rst & ~w_hazard & (~r_ex_valid | ex_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      r_ex_valid <= 1'b0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_rd    <= '0;
      r_ex_wen   <= 1'b0;
      r_ex_op    <= '0;
    end else begin
      // A set on the same register as a clear wins: the new writer owns it.
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_accept) begin
        r_ex_valid <= 1'b1;
        r_ex_a     <= w_opa;
        r_ex_b     <= w_opb;
        r_ex_rd    <= dec_rd;
        r_ex_wen   <= dec_wen;
        r_ex_op    <= dec_op;
      end else if (ex_ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_a     = r_ex_a;
  assign ex_b     = r_ex_b;
  assign ex_rd    = r_ex_rd;
  assign ex_wen   = r_ex_wen;
  assign ex_op    = r_ex_op;

endmodule
